motion_bus_hub: RTL and testbench

Parametrised interconnect between the uP-side bus master and a variable number of slave channels (QE, PWM, RC servo, system info). It replaces the single shared handshake line pair with one-hot per-slave select and acknowledge. It adds address decode, a per-transaction acknowledge watchdog, and an error status returned to the master. It sits between `uP_interface` and the channel array in `motion_system`.

---
 rtl/motion_bus_hub_pkg.sv | 31 +++
 rtl/motion_bus_hub_watchdog.sv | 30 +++
 rtl/motion_bus_hub.sv | 221 ++++++++++++++++++++++
 tb/tb_motion_bus_hub.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/motion_bus_hub_pkg.sv
// Shared types and constants for the motion bus hub: FSM states, response status codes,
// the statistics slave id and its register map.
package motion_bus_hub_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_WAIT_ACK,
        ST_RESPOND,
        ST_RELEASE
    } hub_state_t;

    typedef enum logic [1:0] {
        HUB_OK       = 2'b00,
        HUB_NO_SLAVE = 2'b01,
        HUB_TIMEOUT  = 2'b10
    } hub_status_t;

    localparam logic [7:0] HUB_STATS_ID = 8'hFF;

    localparam int STATS_REG_DONE     = 0;
    localparam int STATS_REG_TIMEOUT  = 1;
    localparam int STATS_REG_NO_SLAVE = 2;
    localparam int STATS_REG_CLEAR    = 3;

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (&value) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/motion_bus_hub_watchdog.sv
// Acknowledge watchdog for the motion bus hub: reloads on clear, counts down while enabled,
// and flags expiry on the cycle the count is exhausted.
module hub_watchdog #(
    parameter int CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expired
);

    localparam int CW = $clog2(CYCLES);
    localparam logic [CW-1:0] LOAD = CW'(CYCLES - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= LOAD;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - CW'(1);
        end
    end

    assign o_expired = i_en && (r_count == '0);

endmodule

// File: rtl/motion_bus_hub.sv
// Bus hub between the uP master and NUM_SLAVES channels: one-hot select, ack watchdog, status.
// Define MOTION_HUB_STATS_EN to add the internal statistics slave at id 8'hFF.
module motion_bus_hub
    import motion_bus_hub_pkg::*;
#(
    parameter int NUM_SLAVES     = 8,
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         m_cmd_valid,
    input  logic                         m_rw,
    input  logic [7:0]                   m_slave_id,
    input  logic [ADDR_W-1:0]            m_reg_addr,
    input  logic [DATA_W-1:0]            m_wdata,
    output logic                         m_ack,
    output logic [DATA_W-1:0]            m_rdata,
    output logic [1:0]                   m_status,
    output logic                         busy,
    output logic [NUM_SLAVES-1:0]        s_sel,
    output logic                         s_rw,
    output logic [ADDR_W-1:0]            s_reg_addr,
    output logic [DATA_W-1:0]            s_wdata,
    input  logic [NUM_SLAVES-1:0]        s_ack,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata
);

    hub_state_t             r_state, w_state_nxt;
    hub_status_t            r_status, w_status_nxt;
    logic                   r_ack, w_ack_nxt;
    logic [DATA_W-1:0]      r_rdata, w_rdata_nxt;
    logic [NUM_SLAVES-1:0]  r_sel, w_sel_nxt;
    logic                   r_rw, w_rw_nxt;
    logic [7:0]             r_id, w_id_nxt;
    logic [ADDR_W-1:0]      r_addr, w_addr_nxt;
    logic [DATA_W-1:0]      r_wdata, w_wdata_nxt;
    logic                   r_abandon, w_abandon_nxt;
    logic [NUM_SLAVES-1:0]  w_onehot;
    logic [DATA_W-1:0]      w_id_rdata;
    logic                   w_id_ack;
    logic                   w_wd_clear, w_wd_en, w_expired;

    // Only the addressed slave's ack and read data are ever looked at.
    always_comb begin
        w_onehot   = '0;
        w_id_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            w_onehot[i] = (int'(r_id) == i);
            if (int'(r_id) == i) begin
                w_id_rdata = s_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_id_ack = |(s_ack & w_onehot);

    hub_watchdog #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_wd_clear),
        .i_en      (w_wd_en),
        .o_expired (w_expired)
    );

`ifdef MOTION_HUB_STATS_EN
    logic [31:0]       r_cnt_done, r_cnt_timeout, r_cnt_no_slave;
    logic [DATA_W-1:0] w_stats_rdata;
    logic              w_stats_clear, w_respond_entry;

    always_comb begin
        w_stats_rdata = '0;
        if (r_addr == ADDR_W'(STATS_REG_DONE)) begin
            w_stats_rdata = DATA_W'(r_cnt_done);
        end else if (r_addr == ADDR_W'(STATS_REG_TIMEOUT)) begin
            w_stats_rdata = DATA_W'(r_cnt_timeout);
        end else if (r_addr == ADDR_W'(STATS_REG_NO_SLAVE)) begin
            w_stats_rdata = DATA_W'(r_cnt_no_slave);
        end
    end

    assign w_stats_clear   = (r_state == ST_DECODE) && (r_id == HUB_STATS_ID) && !r_rw
                             && (r_addr == ADDR_W'(STATS_REG_CLEAR));
    assign w_respond_entry = (w_state_nxt == ST_RESPOND) && (r_state != ST_RESPOND);

    // A clear beats the increment of the clearing transaction itself.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt_done     <= '0;
            r_cnt_timeout  <= '0;
            r_cnt_no_slave <= '0;
        end else if (w_stats_clear) begin
            r_cnt_done     <= '0;
            r_cnt_timeout  <= '0;
            r_cnt_no_slave <= '0;
        end else if (w_respond_entry) begin
            case (w_status_nxt)
                HUB_OK:       r_cnt_done     <= sat_inc(r_cnt_done);
                HUB_TIMEOUT:  r_cnt_timeout  <= sat_inc(r_cnt_timeout);
                HUB_NO_SLAVE: r_cnt_no_slave <= sat_inc(r_cnt_no_slave);
                default:      r_cnt_done     <= r_cnt_done;
            endcase
        end
    end
`endif

    // r_abandon marks a master that dropped m_cmd_valid before seeing m_ack; its ack is a one-cycle pulse.
    always_comb begin
        w_state_nxt   = r_state;
        w_status_nxt  = r_status;
        w_ack_nxt     = r_ack;
        w_rdata_nxt   = r_rdata;
        w_sel_nxt     = r_sel;
        w_rw_nxt      = r_rw;
        w_id_nxt      = r_id;
        w_addr_nxt    = r_addr;
        w_wdata_nxt   = r_wdata;
        w_abandon_nxt = r_abandon;
        w_wd_clear    = 1'b0;
        w_wd_en       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (m_cmd_valid) begin
                    w_rw_nxt      = m_rw;
                    w_id_nxt      = m_slave_id;
                    w_addr_nxt    = m_reg_addr;
                    w_wdata_nxt   = m_wdata;
                    w_abandon_nxt = 1'b0;
                    w_state_nxt   = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (!m_cmd_valid) w_abandon_nxt = 1'b1;
                if (int'(r_id) < NUM_SLAVES) begin
                    w_sel_nxt   = w_onehot;
                    w_wd_clear  = 1'b1;
                    w_state_nxt = ST_WAIT_ACK;
`ifdef MOTION_HUB_STATS_EN
                end else if (r_id == HUB_STATS_ID) begin
                    w_status_nxt = HUB_OK;
                    w_rdata_nxt  = r_rw ? w_stats_rdata : '0;
                    w_ack_nxt    = 1'b1;
                    w_state_nxt  = ST_RESPOND;
`endif
                end else begin
                    w_status_nxt = HUB_NO_SLAVE;
                    w_rdata_nxt  = '0;
                    w_ack_nxt    = 1'b1;
                    w_state_nxt  = ST_RESPOND;
                end
            end
            ST_WAIT_ACK: begin
                if (!m_cmd_valid) w_abandon_nxt = 1'b1;
                w_wd_en = 1'b1;
                if (w_id_ack) begin
                    w_status_nxt = HUB_OK;
                    w_rdata_nxt  = r_rw ? w_id_rdata : '0;
                    w_sel_nxt    = '0;
                    w_ack_nxt    = 1'b1;
                    w_state_nxt  = ST_RESPOND;
                end else if (w_expired) begin
                    w_status_nxt = HUB_TIMEOUT;
                    w_rdata_nxt  = '0;
                    w_sel_nxt    = '0;
                    w_ack_nxt    = 1'b1;
                    w_state_nxt  = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                if (r_abandon) w_ack_nxt = 1'b0;
                w_state_nxt = ST_RELEASE;
            end
            ST_RELEASE: begin
                if ((r_abandon || !m_cmd_valid) && ((r_status != HUB_OK) || !w_id_ack)) begin
                    w_ack_nxt   = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_status  <= HUB_OK;
            r_ack     <= 1'b0;
            r_rdata   <= '0;
            r_sel     <= '0;
            r_rw      <= 1'b0;
            r_id      <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_abandon <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_status  <= w_status_nxt;
            r_ack     <= w_ack_nxt;
            r_rdata   <= w_rdata_nxt;
            r_sel     <= w_sel_nxt;
            r_rw      <= w_rw_nxt;
            r_id      <= w_id_nxt;
            r_addr    <= w_addr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_abandon <= w_abandon_nxt;
        end
    end

    assign m_ack      = r_ack;
    assign m_rdata    = r_rdata;
    assign m_status   = r_status;
    assign busy       = (r_state != ST_IDLE);
    assign s_sel      = r_sel;
    assign s_rw       = r_rw;
    assign s_reg_addr = r_addr;
    assign s_wdata    = r_wdata;

endmodule

// File: tb/tb_motion_bus_hub.sv
// Self-checking bench for motion_bus_hub: directed and randomized transactions against a
// cycle-numbered model of the hub's handshake, with bench-side slaves backed by a register array.
module tb_motion_bus_hub;

    localparam int NS  = 8;
    localparam int DW  = 32;
    localparam int AW  = 8;
    localparam int TMO = 16;

    logic           clk;
    logic           reset;
    logic           m_cmd_valid;
    logic           m_rw;
    logic [7:0]     m_slave_id;
    logic [AW-1:0]  m_reg_addr;
    logic [DW-1:0]  m_wdata;
    logic           m_ack;
    logic [DW-1:0]  m_rdata;
    logic [1:0]     m_status;
    logic           busy;
    logic [NS-1:0]  s_sel;
    logic           s_rw;
    logic [AW-1:0]  s_reg_addr;
    logic [DW-1:0]  s_wdata;
    logic [NS-1:0]  s_ack;
    logic [NS*DW-1:0] s_rdata;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] refMem   [NS][16];
    logic [31:0] slaveMem [NS][16];
    int statDone, statTmo, statNoSlave;

    motion_bus_hub #(
        .NUM_SLAVES     (NS),
        .DATA_W         (DW),
        .ADDR_W         (AW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .m_cmd_valid (m_cmd_valid),
        .m_rw        (m_rw),
        .m_slave_id  (m_slave_id),
        .m_reg_addr  (m_reg_addr),
        .m_wdata     (m_wdata),
        .m_ack       (m_ack),
        .m_rdata     (m_rdata),
        .m_status    (m_status),
        .busy        (busy),
        .s_sel       (s_sel),
        .s_rw        (s_rw),
        .s_reg_addr  (s_reg_addr),
        .s_wdata     (s_wdata),
        .s_ack       (s_ack),
        .s_rdata     (s_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_mAck"}, 64'(m_ack), 64'd0);
        checkOutput({tag, "_mRdata"}, 64'(m_rdata), 64'd0);
        checkOutput({tag, "_mStatus"}, 64'(m_status), 64'd0);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "_sSel"}, 64'(s_sel), 64'd0);
        checkOutput({tag, "_sRw"}, 64'(s_rw), 64'd0);
        checkOutput({tag, "_sRegAddr"}, 64'(s_reg_addr), 64'd0);
        checkOutput({tag, "_sWdata"}, 64'(s_wdata), 64'd0);
    endtask

    // Period p means the clock period after p edges since the command was first sampled.
    // Slave acks d periods after select appears; master drops valid vHold periods after m_ack
    // (or right after launch when dropEarly); slave drops ack aHold periods after m_ack.
    task automatic applyStimulus(input bit rw, input logic [7:0] id, input logic [7:0] addr,
                                 input logic [31:0] wd, input int d, input int vHold,
                                 input int aHold, input bit dropEarly);
        bit isSlave, isStats, timedOut, okWait, slaveAck, expAck;
        int ackCyc, exitEdge;
        logic [1:0]  expStatus;
        logic [31:0] expRdata;
        logic [7:0]  expSel;
        isSlave  = (int'(id) < NS);
        isStats  = 1'b0;
`ifdef MOTION_HUB_STATS_EN
        isStats  = (id == 8'hFF);
`endif
        timedOut = isSlave && (d >= TMO);
        okWait   = isSlave && !timedOut;
        if (!isSlave)     ackCyc = 2;
        else if (timedOut) ackCyc = 2 + TMO;
        else              ackCyc = 3 + d;
        if (okWait || isStats) expStatus = 2'b00;
        else if (timedOut)     expStatus = 2'b10;
        else                   expStatus = 2'b01;
        expRdata = 32'd0;
        if (okWait && rw) expRdata = refMem[id[2:0]][addr[3:0]];
        if (isStats && rw) begin
            case (addr)
                8'd0:    expRdata = 32'(statDone);
                8'd1:    expRdata = 32'(statTmo);
                8'd2:    expRdata = 32'(statNoSlave);
                default: expRdata = 32'd0;
            endcase
        end
        exitEdge = ackCyc + 1;
        if (!dropEarly && (ackCyc + vHold > exitEdge)) exitEdge = ackCyc + vHold;
        if (okWait && (ackCyc + aHold > exitEdge))     exitEdge = ackCyc + aHold;
        expSel = 8'h00;
        if (isSlave) expSel[id[2:0]] = 1'b1;

        m_cmd_valid = 1'b1;
        m_rw        = rw;
        m_slave_id  = id;
        m_reg_addr  = addr;
        m_wdata     = wd;
        for (int p = 1; p <= exitEdge + 1; p++) begin
            @(posedge clk);
            #1;
            expAck = dropEarly ? (p == ackCyc) : (p >= ackCyc && p <= exitEdge);
            checkOutput("mAck", 64'(m_ack), 64'(expAck));
            checkOutput("busy", 64'(busy), 64'(p <= exitEdge));
            checkOutput("sSel", 64'(s_sel), (isSlave && p >= 2 && p < ackCyc) ? 64'(expSel) : 64'd0);
            if (p <= exitEdge) begin
                checkOutput("sRw", 64'(s_rw), 64'(rw));
                checkOutput("sRegAddr", 64'(s_reg_addr), 64'(addr));
                checkOutput("sWdata", 64'(s_wdata), 64'(wd));
            end
            if (p == ackCyc) begin
                checkOutput("mStatus", 64'(m_status), 64'(expStatus));
                checkOutput("mRdata", 64'(m_rdata), 64'(expRdata));
            end
            if (dropEarly && p == 1) begin
                m_cmd_valid = 1'b0;
                m_rw        = ~rw;
                m_slave_id  = 8'($urandom);
                m_reg_addr  = 8'($urandom);
                m_wdata     = $urandom;
            end
            if (!dropEarly && p == ackCyc + vHold) m_cmd_valid = 1'b0;
            slaveAck = isSlave && ((!timedOut && p >= 2 + d && p < ackCyc + aHold) ||
                                   (timedOut && p >= ackCyc && p < ackCyc + aHold));
            s_ack = 8'($urandom);
            for (int k = 0; k < NS; k++) s_rdata[k*DW +: DW] = $urandom;
            if (isSlave) begin
                s_ack[id[2:0]] = slaveAck;
                s_rdata[int'(id[2:0])*DW +: DW] = slaveMem[id[2:0]][s_reg_addr[3:0]];
                if (slaveAck && !timedOut && p == 2 + d && !s_rw)
                    slaveMem[id[2:0]][s_reg_addr[3:0]] = s_wdata;
            end
        end
        s_ack = '0;

        if (okWait && !rw) refMem[id[2:0]][addr[3:0]] = wd;
        if (isStats && !rw && addr == 8'd3) begin
            statDone = 0; statTmo = 0; statNoSlave = 0;
        end else if (expStatus == 2'b00) statDone++;
        else if (expStatus == 2'b10)     statTmo++;
        else                             statNoSlave++;
    endtask

    initial begin
        logic [7:0]  rId, rAddr;
        logic [31:0] rData;
        int          rSel, rD;

        reset       = 1'b0;
        m_cmd_valid = 1'b0;
        m_rw        = 1'b0;
        m_slave_id  = '0;
        m_reg_addr  = '0;
        m_wdata     = '0;
        s_ack       = '0;
        s_rdata     = '0;
        statDone = 0; statTmo = 0; statNoSlave = 0;
        for (int i = 0; i < NS; i++) begin
            for (int r = 0; r < 16; r++) begin
                refMem[i][r]   = {8'(i), 8'(r), 16'hA5C3};
                slaveMem[i][r] = {8'(i), 8'(r), 16'hA5C3};
            end
        end
        refMem[3][1]   = 32'h1234_5678;
        slaveMem[3][1] = 32'h1234_5678;

        repeat (2) @(posedge clk);
        #1;
        checkResetValues("resetHeld");
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkResetValues("afterReset");

        $display("[TB] directed transactions");
        applyStimulus(1'b1, 8'd3, 8'd1, 32'h0, 0, 0, 0, 1'b0);
        applyStimulus(1'b0, 8'd0, 8'd5, 32'hCAFE_0001, 0, 1, 2, 1'b0);
        applyStimulus(1'b1, 8'd0, 8'd5, 32'h0, 1, 0, 0, 1'b0);
        applyStimulus(1'b1, 8'd9, 8'd0, 32'h5555_AAAA, 0, 0, 0, 1'b0);
        applyStimulus(1'b1, 8'd1, 8'd2, 32'h0, TMO, 0, 2, 1'b0);
        applyStimulus(1'b1, 8'd4, 8'd7, 32'h0, TMO - 1, 2, 1, 1'b0);
        applyStimulus(1'b1, 8'd6, 8'd3, 32'h0, 2, 0, 0, 1'b1);
        applyStimulus(1'b0, 8'd7, 8'd4, 32'h0BAD_F00D, 0, 0, 3, 1'b1);
        applyStimulus(1'b1, 8'd20, 8'd0, 32'h0, 0, 0, 0, 1'b1);
        applyStimulus(1'b1, 8'hFF, 8'd0, 32'h0, 0, 0, 0, 1'b0);

        $display("[TB] randomized transactions");
        for (int n = 0; n < 40; n++) begin
            rSel = $urandom_range(0, 9);
            if (rSel < 7)       rId = 8'($urandom_range(0, NS - 1));
            else if (rSel == 7) rId = 8'hFF;
            else                rId = 8'($urandom_range(NS, 254));
            rAddr = 8'($urandom_range(0, 15));
            rData = $urandom;
            rD    = ($urandom_range(0, 7) == 0) ? TMO : $urandom_range(0, 4);
            applyStimulus(1'($urandom), rId, rAddr, rData, rD, $urandom_range(0, 2),
                          $urandom_range(0, 2), ($urandom_range(0, 5) == 0));
        end

        $display("[TB] reset during WAIT_ACK");
        m_cmd_valid = 1'b1;
        m_rw        = 1'b1;
        m_slave_id  = 8'd2;
        m_reg_addr  = 8'h0A;
        m_wdata     = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("preResetSel", 64'(s_sel), 64'h04);
        #2;
        reset = 1'b0;
        #1;
        checkResetValues("midReset");
        statDone = 0; statTmo = 0; statNoSlave = 0;
        @(posedge clk);
        #1;
        reset       = 1'b1;
        m_cmd_valid = 1'b0;
        s_ack       = 8'h04;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            s_ack = '0;
            checkOutput("noLateAck", 64'(m_ack), 64'd0);
            checkOutput("idleAfterReset", 64'(busy), 64'd0);
        end
        applyStimulus(1'b1, 8'd2, 8'd10, 32'h0, 1, 0, 0, 1'b0);

        $display("[TB] statistics slave");
        applyStimulus(1'b0, 8'd5, 8'd2, 32'h0000_0F0F, 0, 0, 0, 1'b0);
        applyStimulus(1'b1, 8'd5, 8'd2, 32'h0, 2, 1, 1, 1'b0);
        applyStimulus(1'b1, 8'd1, 8'd0, 32'h0, TMO, 0, 0, 1'b0);
        applyStimulus(1'b1, 8'd12, 8'd0, 32'h0, 0, 0, 0, 1'b0);
        applyStimulus(1'b1, 8'hFF, 8'd0, 32'h0, 0, 0, 0, 1'b0);
        applyStimulus(1'b1, 8'hFF, 8'd1, 32'h0, 0, 0, 0, 1'b0);
        applyStimulus(1'b1, 8'hFF, 8'd2, 32'h0, 0, 1, 0, 1'b0);
        applyStimulus(1'b0, 8'hFF, 8'd3, 32'h1, 0, 0, 0, 1'b0);
        applyStimulus(1'b1, 8'hFF, 8'd0, 32'h0, 0, 0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
